// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad pin and key-event bundle for the keypad scanner
interface keypad_scanner_if;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       multi_key;

  modport master (
    output col_in,
    input  row_out, key_code, key_valid, key_held, multi_key
  );

  modport slave (
    input  col_in,
    output row_out, key_code, key_valid, key_held, multi_key
  );
endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 active-low keypad row scanner with whole-frame debounce
module keypad_scanner #(
  parameter int SCAN_CYCLES    = 250_000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  keypad_scanner_if.slave   kp
);
  localparam int             CW        = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [CW-1:0]  SLOT_LAST = CW'(SCAN_CYCLES - 1);
  localparam logic [3:0]     DB        = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, PRESSED, MULTI, WAIT_REL} state_t;
  typedef enum logic [1:0] {CLS_NONE, CLS_ONE, CLS_MULTI} cls_t;

  logic [3:0]    col_s1_q, col_s1_d, col_s2_q, col_s2_d;
  logic [CW-1:0] slot_q, slot_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [15:0]   snapshot_q, snapshot_d;
  cls_t          prev_cls_q, prev_cls_d;
  logic [3:0]    prev_code_q, prev_code_d;
  logic [3:0]    stable_cnt_q, stable_cnt_d;
  state_t        state_q, state_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;
  logic          multi_key_q, multi_key_d;

  logic          sample, frame_end, same, accept;
  logic [4:0]    ones;
  logic [3:0]    code;
  cls_t          cls;
  logic [3:0]    cnt_next;

  always_comb begin
    col_s1_d     = kp.col_in;
    col_s2_d     = col_s1_q;
    sample       = (slot_q == SLOT_LAST);
    frame_end    = sample && (row_idx_q == 2'd3);
    slot_d       = sample ? '0 : slot_q + 1'b1;
    row_idx_d    = sample ? row_idx_q + 2'd1 : row_idx_q;
    snapshot_d   = snapshot_q;
    if (sample) snapshot_d[{row_idx_q, 2'b00} +: 4] = ~col_s2_q;

    // The last row is merged combinationally so the frame is classified on its own sample cycle.
    ones = '0;
    code = '0;
    for (int i = 0; i < 16; i++) begin
      if (snapshot_d[i]) begin
        ones = ones + 5'd1;
        code = 4'(i);
      end
    end
    cls = (ones == 5'd0) ? CLS_NONE : (ones == 5'd1) ? CLS_ONE : CLS_MULTI;

    same     = (cls == prev_cls_q) && ((cls != CLS_ONE) || (code == prev_code_q));
    cnt_next = same ? ((stable_cnt_q == DB) ? DB : stable_cnt_q + 4'd1) : 4'd1;
    accept   = frame_end && (cnt_next == DB) && !(same && (stable_cnt_q == DB));

    stable_cnt_d = frame_end ? cnt_next : stable_cnt_q;
    prev_cls_d   = frame_end ? cls : prev_cls_q;
    prev_code_d  = frame_end ? code : prev_code_q;

    state_d     = state_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    multi_key_d = multi_key_q;
    if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (cls == CLS_ONE) begin
            state_d     = PRESSED;
            key_code_d  = code;
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
          end else if (cls == CLS_MULTI) begin
            state_d     = MULTI;
            multi_key_d = 1'b1;
          end
        end
        PRESSED: begin
          if (cls == CLS_NONE) begin
            state_d    = IDLE;
            key_held_d = 1'b0;
          end else if (cls == CLS_MULTI || code != key_code_q) begin
            // No rollover: a second key only parks us until everything is released.
            state_d     = WAIT_REL;
            key_held_d  = 1'b0;
            multi_key_d = (cls == CLS_MULTI);
          end
        end
        MULTI: begin
          if (cls == CLS_NONE) begin
            state_d     = IDLE;
            multi_key_d = 1'b0;
          end
        end
        WAIT_REL: begin
          if (cls == CLS_NONE) state_d = IDLE;
          multi_key_d = (cls == CLS_MULTI);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_s1_q     <= 4'hF;
      col_s2_q     <= 4'hF;
      slot_q       <= '0;
      row_idx_q    <= 2'd0;
      snapshot_q   <= '0;
      prev_cls_q   <= CLS_NONE;
      prev_code_q  <= '0;
      stable_cnt_q <= '0;
      state_q      <= IDLE;
      key_code_q   <= '0;
      key_valid_q  <= 1'b0;
      key_held_q   <= 1'b0;
      multi_key_q  <= 1'b0;
    end else begin
      col_s1_q     <= col_s1_d;
      col_s2_q     <= col_s2_d;
      slot_q       <= slot_d;
      row_idx_q    <= row_idx_d;
      snapshot_q   <= snapshot_d;
      prev_cls_q   <= prev_cls_d;
      prev_code_q  <= prev_code_d;
      stable_cnt_q <= stable_cnt_d;
      state_q      <= state_d;
      key_code_q   <= key_code_d;
      key_valid_q  <= key_valid_d;
      key_held_q   <= key_held_d;
      multi_key_q  <= multi_key_d;
    end
  end

  assign kp.row_out   = ~(4'b0001 << row_idx_q);
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;
  assign kp.multi_key = multi_key_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner with a frame-level reference model
module tb_keypad_scanner;
  localparam int SC = 4;
  localparam int DB = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] keys = '0;
  int cyc = 0;
  int base = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct { logic [3:0] code; int due; } exp_t;
  exp_t exp_q[$];

  keypad_scanner_if kp ();

  keypad_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE_SCANS(DB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Physical keypad: a pressed key shorts its column to whichever row is driven low.
  always_comb begin
    kp.col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kp.row_out[r]) kp.col_in[c] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: one call per frame; a press is accepted when the same
  // frame signature has been seen exactly DB times in a row since reset.
  int m_state, m_prev_sig, m_run;
  logic [3:0] m_code;
  logic m_held, m_multi;

  function automatic void model_reset();
    m_state = 0; m_prev_sig = 16; m_run = 0;
    m_code = '0; m_held = 1'b0; m_multi = 1'b0;
  endfunction

  function automatic void model_frame(input logic [15:0] k, input int due);
    int n, sig;
    exp_t e;
    n = $countones(k);
    sig = 17;
    if (n == 0) sig = 16;
    else if (n == 1) for (int i = 0; i < 16; i++) if (k[i]) sig = i;
    m_run = (sig == m_prev_sig) ? m_run + 1 : 1;
    m_prev_sig = sig;
    if (m_run != DB) return;
    case (m_state)
      0: if (sig < 16) begin
           m_state = 1; m_code = 4'(sig); m_held = 1'b1;
           e.code = 4'(sig); e.due = due; exp_q.push_back(e);
         end else if (sig == 17) begin
           m_state = 2; m_multi = 1'b1;
         end
      1: if (sig == 16) begin
           m_state = 0; m_held = 1'b0;
         end else if (sig == 17 || sig != int'(m_code)) begin
           m_state = 3; m_held = 1'b0; m_multi = (sig == 17);
         end
      2: if (sig == 16) begin m_state = 0; m_multi = 1'b0; end
      default: begin
        if (sig == 16) m_state = 0;
        m_multi = (sig == 17);
      end
    endcase
  endfunction

  task automatic run_frame(input logic [15:0] k);
    logic [3:0] exp_row;
    logic [3:0] one;
    keys = k;
    model_frame(k, cyc + 4 * SC);
    for (int i = 0; i < 4 * SC; i++) begin
      one = 4'b0001;
      exp_row = ~(one << 2'(((cyc - base) / SC) % 4));
      chk("row_out", kp.row_out, exp_row);
      @(negedge clk);
    end
    chk("key_held", kp.key_held, m_held);
    chk("multi_key", kp.multi_key, m_multi);
    chk("key_code", kp.key_code, m_code);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_row_out", kp.row_out, 4'b1110);
    chk("rst_key_code", kp.key_code, 4'd0);
    chk("rst_key_valid", kp.key_valid, 1'b0);
    chk("rst_key_held", kp.key_held, 1'b0);
    chk("rst_multi_key", kp.multi_key, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (kp.key_valid) begin
        if (exp_q.size() == 0) chk("spurious_valid", kp.key_valid, 1'b0);
        else begin
          e = exp_q.pop_front();
          chk("valid_code", kp.key_code, e.code);
          chk("valid_time", cyc, e.due);
        end
      end else if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        e = exp_q.pop_front();
        chk("missed_valid", kp.key_valid, 1'b1);
      end
    end
  end

  initial begin
    logic [15:0] pat;
    logic [15:0] one16;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;
    base = cyc;

    repeat (10) run_frame(16'h0000);
    repeat (5) run_frame(16'h0040);
    repeat (3) run_frame(16'h0000);
    for (int i = 0; i < 8; i++) run_frame((i % 2 == 0) ? 16'h0040 : 16'h0000);
    repeat (3) run_frame(16'h0000);
    repeat (4) run_frame(16'h0240);
    repeat (3) run_frame(16'h0000);
    repeat (3) run_frame(16'h0040);
    repeat (3) run_frame(16'h0000);
    repeat (3) run_frame(16'h8000);
    repeat (3) run_frame(16'h0000);

    run_frame(16'h0008);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    base = cyc;
    model_reset();
    repeat (4) run_frame(16'h0008);
    repeat (3) run_frame(16'h0000);

    pat = '0;
    one16 = 16'h0001;
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0:       pat = '0;
          1, 2:    pat = one16 << $urandom_range(0, 15);
          default: pat = (one16 << $urandom_range(0, 15)) | (one16 << $urandom_range(0, 15));
        endcase
      end
      run_frame(pat);
    end
    repeat (4) run_frame(16'h0000);
    chk("pending_expect", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
